scan_ctrl: RTL and testbench
============================

SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 SHALL have parameter N, default 8: scan chain length in bits, N >= 2.
REQ-002 SHALL have port CLK, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port CLR, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port START, input, 1: request one scan operation; sampled only in IDLE.
REQ-005 SHALL have port CAP, input, 1: request a capture cycle after the shift; sampled with START.
REQ-006 SHALL have port LOAD_DATA, input, N: pattern to shift into the chain; sampled with START.
REQ-007 SHALL have port SCANOUT, input, 1: chain serial output, equal to chain Q[N-1].
REQ-008 SHALL have port TEST, output, 1: chain shift enable.
REQ-009 SHALL have port HOLD, output, 1: chain hold when TEST=0.
REQ-010 SHALL have port SCANIN, output, 1: chain serial input, shifted into Q[0].
REQ-011 SHALL have port UNLOAD_DATA, output, N: chain contents shifted out during the last operation.
REQ-012 SHALL have port BUSY, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port DONE, output, 1: one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, SHIFT, CAPTURE and DONE, with TEST, HOLD and SCANIN decoded only from registered state.
REQ-015 IDLE SHALL drive TEST=0, HOLD=1 and SCANIN=0; START=1 SHALL latch LOAD_DATA and CAP, clear the bit counter, and go to SHIFT.
REQ-016 SHIFT SHALL last exactly N cycles with TEST=1; in shift cycle k (k=0..N-1), SCANIN SHALL equal latched LOAD_DATA[N-1-k], MSB first.
REQ-017 On each rising edge ending a shift cycle, UNLOAD_DATA SHALL become {UNLOAD_DATA[N-2:0], SCANOUT}, so that after N shifts it holds the pre-operation chain word unreordered.
REQ-018 After the last shift cycle, the FSM SHALL go to CAPTURE if CAP was latched, otherwise to DONE.
REQ-019 CAPTURE SHALL last one cycle with TEST=0 and HOLD=0 (chain loads D), then go to DONE.
REQ-020 DONE SHALL last one cycle with DONE=1, TEST=0, HOLD=1, then return to IDLE.
REQ-021 Latency from the START-sampling edge to the DONE cycle SHALL be N+1 cycles without CAP and N+2 cycles with CAP.
REQ-022 START outside IDLE, including in the DONE cycle, SHALL be ignored, with no queuing.
REQ-023 UNLOAD_DATA SHALL be stable outside SHIFT and SHALL be retained until the next operation's first shift edge.
REQ-024 The bit counter SHALL be $clog2(N) bits wide, with the terminal count N-1 handled without overflow for N a power of two.

Reset
REQ-025 While CLR=0, the block SHALL immediately force IDLE, TEST=0, HOLD=1, SCANIN=0, BUSY=0, DONE=0, UNLOAD_DATA=0 and counter=0.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no DONE pulse; the next START SHALL run a full N-cycle shift.

Configuration
REQ-027 With SCAN_CTRL_COMPARE_EN defined, the block SHALL add input EXPECT[N-1:0] (sampled with START) and output MISMATCH, with MISMATCH = (UNLOAD_DATA != latched EXPECT) updated in the DONE cycle, held until the next DONE, and reset to 0.
REQ-028 Without SCAN_CTRL_COMPARE_EN, the EXPECT/MISMATCH ports and their logic SHALL be absent, with all other behaviour unchanged.

Structure
REQ-029 Shared package scan_pkg SHALL hold the state enumeration type and the default chain length constant.
REQ-030 The bit counter SHALL be a sub-module scan_cnt (load-zero, increment, terminal-count flag); all other logic stays in scan_ctrl.

Verification (N=8, chain = existing scan register model)
REQ-031 CLR=0 during activity -> TEST=0, HOLD=1, SCANIN=0, BUSY=0, UNLOAD_DATA=0x00 in the same cycle.
REQ-032 Chain preloaded 0xA5, START with LOAD_DATA=0x3C and CAP=0 -> TEST high exactly 8 cycles, SCANIN sequence 0,0,1,1,1,1,0,0, chain=0x3C, UNLOAD_DATA=0xA5, DONE 9 cycles after START.
REQ-033 Chain 0x3C, chain D=0x5A, START with CAP=1 -> one cycle TEST=0 and HOLD=0 after the shift, chain=0x5A, UNLOAD_DATA=0x3C, DONE after 10 cycles.
REQ-034 START pulsed in shift cycle 3 and in the DONE cycle -> no extra operation, exactly one DONE pulse.
REQ-035 CLR low in shift cycle 4, then a new START with LOAD_DATA=0xFF -> no DONE for the aborted operation; the new operation shifts 8 ones.
REQ-036 With SCAN_CTRL_COMPARE_EN: EXPECT=0xA5 against unload 0xA5 -> MISMATCH=0; EXPECT=0xA4 -> MISMATCH=1.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared scan-control definitions: FSM state encoding and default chain length.
package scan_pkg;

    localparam int unsigned SCAN_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/scan_cnt.sv
// Shift bit counter: load-zero, increment, terminal-count flag at N-1.
// Incrementing at terminal count wraps to zero explicitly, so no overflow for any N.
module scan_cnt #(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [$clog2(N)-1:0] cnt,
    output logic                 tc_c
);

    localparam int unsigned W = $clog2(N);

    // Terminal count marks the last shift cycle
    assign tc_c = (cnt == W'(N - 1));

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc_c ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/scan_ctrl.sv
// Scan chain controller: shifts a pattern into the chain MSB first while
// collecting the old chain contents, with an optional capture cycle.
// Optional feature: define SCAN_CTRL_COMPARE_EN to add EXPECT/MISMATCH.
module scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned N = SCAN_N_DEFAULT
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         START,
    input  logic         CAP,
    input  logic [N-1:0] LOAD_DATA,
    input  logic         SCANOUT,
`ifdef SCAN_CTRL_COMPARE_EN
    input  logic [N-1:0] EXPECT,
    output logic         MISMATCH,
`endif
    output logic         TEST,
    output logic         HOLD,
    output logic         SCANIN,
    output logic [N-1:0] UNLOAD_DATA,
    output logic         BUSY,
    output logic         DONE
);

    localparam int unsigned CW = $clog2(N);

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    pat_q;
    logic            cap_q;
    logic [CW-1:0]   cnt;
    logic            tc_c;
    logic            start_acc;
    logic            cnt_inc;
    logic [N-1:0]    unload_nxt;

    // START is only honoured in IDLE; anything else is dropped
    assign start_acc  = (state == ST_IDLE) && START;
    assign unload_nxt = {UNLOAD_DATA[N-2:0], SCANOUT};

    scan_cnt #(.N(N)) u_cnt (
        .clk   (CLK),
        .rst_n (CLR),
        .clr   (start_acc),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .tc_c  (tc_c)
    );

    // State register
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start_acc) state_nxt = ST_SHIFT;
            ST_SHIFT:   if (tc_c) state_nxt = cap_q ? ST_CAPTURE : ST_DONE;
            ST_CAPTURE: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Chain control decoded from registered state
    always_comb begin
        TEST    = 1'b0;
        HOLD    = 1'b1;
        SCANIN  = 1'b0;
        BUSY    = 1'b0;
        DONE    = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            ST_SHIFT: begin
                TEST    = 1'b1;
                SCANIN  = pat_q[CW'(N - 1) - cnt];
                BUSY    = 1'b1;
                cnt_inc = 1'b1;
            end
            ST_CAPTURE: begin
                HOLD = 1'b0;
                BUSY = 1'b1;
            end
            ST_DONE: begin
                DONE = 1'b1;
                BUSY = 1'b1;
            end
            default: ;
        endcase
    end

    // Latch operation parameters and collect the shifted-out chain word
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            pat_q       <= '0;
            cap_q       <= 1'b0;
            UNLOAD_DATA <= '0;
        end else begin
            if (start_acc) begin
                pat_q <= LOAD_DATA;
                cap_q <= CAP;
            end
            if (state == ST_SHIFT) begin
                UNLOAD_DATA <= unload_nxt;
            end
        end
    end

`ifdef SCAN_CTRL_COMPARE_EN
    logic [N-1:0] expect_q;

    // Compare the unloaded word against the expectation as DONE is entered
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            expect_q <= '0;
            MISMATCH <= 1'b0;
        end else begin
            if (start_acc) begin
                expect_q <= EXPECT;
            end
            if (state_nxt == ST_DONE) begin
                MISMATCH <= (((state == ST_SHIFT) ? unload_nxt : UNLOAD_DATA) != expect_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: behavioural scan register on the chain side, stimulus
// pushes expected transactions, a monitor checks them at each DONE pulse.
module tb_scan_ctrl;

    localparam int unsigned N = 8;

    logic         CLK;
    logic         CLR;
    logic         START;
    logic         CAP;
    logic [N-1:0] LOAD_DATA;
    logic         SCANOUT;
    logic         TEST;
    logic         HOLD;
    logic         SCANIN;
    logic [N-1:0] UNLOAD_DATA;
    logic         BUSY;
    logic         DONE;
`ifdef SCAN_CTRL_COMPARE_EN
    logic [N-1:0] EXPECT;
    logic         MISMATCH;
`endif

    typedef struct {
        logic [N-1:0] unload;
        logic [N-1:0] chain;
        logic [N-1:0] seq;
        logic         mism;
        int           lat;
        int           caps;
        int           stamp;
    } exp_t;

    exp_t         exp_q[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    logic [N-1:0] chain;
    logic [N-1:0] chain_d;
    logic [N-1:0] preload_val;
    logic         preload;
    logic [N-1:0] model_chain;
    logic [N-1:0] mon_seq;
    int           mon_tcnt;
    int           mon_ccnt;
    logic [N-1:0] prev_unload;
    logic         prev_test;
    logic         prev_clr;

    scan_ctrl #(.N(N)) dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .START       (START),
        .CAP         (CAP),
        .LOAD_DATA   (LOAD_DATA),
        .SCANOUT     (SCANOUT),
`ifdef SCAN_CTRL_COMPARE_EN
        .EXPECT      (EXPECT),
        .MISMATCH    (MISMATCH),
`endif
        .TEST        (TEST),
        .HOLD        (HOLD),
        .SCANIN      (SCANIN),
        .UNLOAD_DATA (UNLOAD_DATA),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Scan register: shift on TEST, load D when not holding
    always @(posedge CLK) begin
        if (preload)    chain <= preload_val;
        else if (TEST)  chain <= {chain[N-2:0], SCANIN};
        else if (!HOLD) chain <= chain_d;
    end
    assign SCANOUT = chain[N-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: accumulate per-operation observations, check on DONE
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!CLR) begin
            mon_seq  = '0;
            mon_tcnt = 0;
            mon_ccnt = 0;
        end else begin
            if (prev_clr && !prev_test && (UNLOAD_DATA !== prev_unload))
                chk("unload_stable", 32'(UNLOAD_DATA), 32'(prev_unload));
            if (TEST) begin
                mon_seq = {mon_seq[N-2:0], SCANIN};
                mon_tcnt++;
            end
            if (BUSY && !TEST && !HOLD) mon_ccnt++;
            if (DONE) begin
                chk("done_has_expect", 32'(exp_q.size() != 0), 32'(1'b1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("unload_data", 32'(UNLOAD_DATA), 32'(e.unload));
                    chk("chain_word", 32'(chain), 32'(e.chain));
                    chk("latency", 32'(cyc - e.stamp), 32'(e.lat));
                    chk("scanin_seq", 32'(mon_seq), 32'(e.seq));
                    chk("test_cycles", 32'(mon_tcnt), 32'(N));
                    chk("capture_cycles", 32'(mon_ccnt), 32'(e.caps));
                    chk("done_ctrl", 32'({BUSY, TEST, HOLD}), 32'(3'b101));
`ifdef SCAN_CTRL_COMPARE_EN
                    chk("mismatch", 32'(MISMATCH), 32'(e.mism));
`endif
                end
                mon_seq  = '0;
                mon_tcnt = 0;
                mon_ccnt = 0;
            end
        end
        prev_unload = UNLOAD_DATA;
        prev_test   = TEST;
        prev_clr    = CLR;
    end

    task automatic do_preload(input logic [N-1:0] v);
        @(posedge CLK); #2;
        preload = 1'b1;
        preload_val = v;
        @(posedge CLK); #2;
        preload = 1'b0;
        model_chain = v;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4 * int'(N); i++) begin
            if (exp_q.size() == 0) break;
            @(posedge CLK);
        end
        chk("op_completes", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
    endtask

    // One operation; glitch adds ignored START pulses in shift cycle 3 and DONE
    task automatic run_op(input logic [N-1:0] load, input logic cap,
                          input logic [N-1:0] d, input bit glitch);
        exp_t e;
        logic [N-1:0] ev;
        @(posedge CLK); #2;
        ev = ($urandom_range(0, 1) != 0) ? model_chain
                                         : model_chain ^ (N'(1) << $urandom_range(0, N - 1));
        START = 1'b1;
        LOAD_DATA = load;
        CAP = cap;
        chain_d = d;
`ifdef SCAN_CTRL_COMPARE_EN
        EXPECT = ev;
`endif
        e.unload = model_chain;
        e.chain  = cap ? d : load;
        e.seq    = load;
        e.mism   = (ev != model_chain);
        e.lat    = cap ? int'(N) + 2 : int'(N) + 1;
        e.caps   = cap ? 1 : 0;
        e.stamp  = cyc;
        exp_q.push_back(e);
        model_chain = e.chain;
        @(posedge CLK); #2;
        START = 1'b0;
        LOAD_DATA = N'($urandom);
        CAP = 1'($urandom);
        if (glitch) begin
            repeat (3) @(posedge CLK);
            #2 START = 1'b1;
            @(posedge CLK); #2;
            START = 1'b0;
            repeat (int'(N) - 4 + (cap ? 1 : 0)) @(posedge CLK);
            #2 START = 1'b1;
            @(posedge CLK); #2;
            START = 1'b0;
        end
        wait_done();
    endtask

    initial begin : stimulus
        logic [N-1:0] old;
        logic [N-1:0] ld;
        CLR = 1'b0;
        START = 1'b0;
        CAP = 1'b0;
        LOAD_DATA = '0;
        chain_d = '0;
        preload = 1'b0;
        preload_val = '0;
        model_chain = '0;
`ifdef SCAN_CTRL_COMPARE_EN
        EXPECT = '0;
`endif
        #3;
        chk("rst_test", 32'(TEST), 32'(1'b0));
        chk("rst_hold", 32'(HOLD), 32'(1'b1));
        chk("rst_scanin", 32'(SCANIN), 32'(1'b0));
        chk("rst_busy", 32'(BUSY), 32'(1'b0));
        chk("rst_done", 32'(DONE), 32'(1'b0));
        chk("rst_unload", 32'(UNLOAD_DATA), 32'(0));
        @(posedge CLK); @(posedge CLK); #2;
        CLR = 1'b1;

        do_preload(N'(8'hA5));
        run_op(N'(8'h3C), 1'b0, N'(8'h00), 1'b0);
        run_op(N'(8'hC3), 1'b1, N'(8'h5A), 1'b0);

        run_op(N'(8'h69), 1'b0, N'(8'h00), 1'b1);
        for (int i = 0; i < int'(N) + 3; i++) begin
            @(negedge CLK);
            chk("no_extra_op", 32'(BUSY), 32'(1'b0));
        end

        // Abort in shift cycle 4: four bits already shifted into the chain
        old = model_chain;
        ld  = N'(8'h96);
        @(posedge CLK); #2;
        START = 1'b1;
        LOAD_DATA = ld;
        CAP = 1'b0;
        @(posedge CLK); #2;
        START = 1'b0;
        repeat (4) @(posedge CLK);
        #2 CLR = 1'b0;
        #1;
        chk("abort_test", 32'(TEST), 32'(1'b0));
        chk("abort_hold", 32'(HOLD), 32'(1'b1));
        chk("abort_scanin", 32'(SCANIN), 32'(1'b0));
        chk("abort_busy", 32'(BUSY), 32'(1'b0));
        chk("abort_unload", 32'(UNLOAD_DATA), 32'(0));
        @(posedge CLK); #2;
        CLR = 1'b1;
        model_chain = {old[N-5:0], ld[N-1:N-4]};
        run_op(N'(8'hFF), 1'b0, N'(8'h00), 1'b0);

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 3) == 0) do_preload(N'($urandom));
            run_op(N'($urandom), 1'($urandom), N'($urandom), ($urandom_range(0, 5) == 0));
        end

        repeat (3) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
